// File: rtl/flag_pkg.sv
// Shared types and constants for the flag stack unit: op encodings, flag indices and
// the stack occupancy-counter width helper.
package flag_pkg;

  typedef enum logic [2:0] {
    OpNop    = 3'b000,
    OpSet    = 3'b001,
    OpClr    = 3'b010,
    OpLoad   = 3'b011,
    OpPush   = 3'b100,
    OpPop    = 3'b101,
    OpToggle = 3'b110,
    OpLoadm  = 3'b111
  } flag_op_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_stack_unit_if.sv
// Command/status bundle for flag_stack_unit: the master drives commands, the slave
// returns the registered flags and stack status.
interface flag_stack_unit_if #(
  parameter int unsigned WIDTH = 8
);
  import flag_pkg::*;

  flag_op_t                    op;
  logic [WIDTH-1:0]            f;
  logic [WIDTH-1:0]            m;
  logic [$clog2(WIDTH)-1:0]    idx;
  logic [WIDTH-1:0]            q;
  logic                        empty;
  logic                        full;
  logic                        err;

  modport master (
    output op, f, m, idx,
    input  q, empty, full, err
  );

  modport slave (
    input  op, f, m, idx,
    output q, empty, full, err
  );

endinterface

// File: rtl/flag_lifo.sv
// Save/restore stack for the flag register. Callers must not push when full or pop
// when empty; dout always presents the top entry.
module flag_lifo
  import flag_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // A depth-1 stack still gets a 1-bit pointer; the spare entry is never written.
  localparam int unsigned MD = (DEPTH > 1) ? DEPTH : 2;

  logic [WIDTH-1:0] mem [MD];
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign wr_ptr = AW'(count_q);
  assign rd_ptr = AW'(count_q - CW'(1));
  assign dout   = mem[rd_ptr];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (push) begin
      count_q <= count_q + CW'(1);
    end else if (pop) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Storage is deliberately not reset; only the occupancy count is.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/flag_stack_unit.sv
// Flag register with bit/bulk update commands and a LIFO save/restore stack.
// Define FLAG_STACK_ERR_EN to get a one-cycle err pulse on dropped PUSH/POP.
module flag_stack_unit
  import flag_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  flag_stack_unit_if.slave  bus
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // An idx past the top bit shifts the one out, so SET/CLR/TOGGLE become no-ops.
  assign bit_mask = WIDTH'(1) << bus.idx;

  always_comb begin
    q_d     = q_q;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    case (bus.op)
      OpSet:    q_d = q_q | bit_mask;
      OpClr:    q_d = q_q & ~bit_mask;
      OpToggle: q_d = q_q ^ bit_mask;
      OpLoad:   q_d = bus.f;
      OpLoadm:  q_d = (q_q & ~bus.m) | (bus.f & bus.m);
      OpPush:   push_ok = !full;
      OpPop: begin
        if (!empty) begin
          pop_ok = 1'b1;
          q_d    = dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  flag_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (q_q),
    .dout  (dout),
    .count (count)
  );

`ifdef FLAG_STACK_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ((bus.op == OpPush) && full) || ((bus.op == OpPop) && empty);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.q     = q_q;
  assign bus.empty = empty;
  assign bus.full  = full;

endmodule

// File: tb/tb_flag_stack_unit.sv
// Scoreboard bench for flag_stack_unit: an 8-bit/depth-4 instance and a 5-bit/depth-1
// instance driven by directed vectors with hand-computed expectations.
module tb_flag_stack_unit;
  import flag_pkg::*;

  typedef struct {
    bit         sel;
    logic [7:0] q;
    bit         empty;
    bit         full;
    bit         err;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  flag_stack_unit_if #(.WIDTH(8)) bus8 ();
  flag_stack_unit_if #(.WIDTH(5)) bus5 ();

  flag_stack_unit #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  flag_stack_unit #(.WIDTH(5), .DEPTH(1)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each posedge consumes the expectation for the command it just sampled.
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] aq;
    logic       ae;
    logic       af;
    logic       ar;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        aq = {3'b000, bus5.q};
        ae = bus5.empty;
        af = bus5.full;
        ar = bus5.err;
      end else begin
        aq = bus8.q;
        ae = bus8.empty;
        af = bus8.full;
        ar = bus8.err;
      end
      check({e.name, ".q"}, aq, e.q);
      check({e.name, ".empty"}, {7'd0, ae}, {7'd0, e.empty});
      check({e.name, ".full"}, {7'd0, af}, {7'd0, e.full});
`ifdef FLAG_STACK_ERR_EN
      check({e.name, ".err"}, {7'd0, ar}, {7'd0, e.err});
`else
      check({e.name, ".err"}, {7'd0, ar}, 8'd0);
`endif
    end
  end

  // sel=0 drives the 8-bit unit, sel=1 the 5-bit unit; the other idles on NOP.
  task automatic step(input bit sel, input bit rst, input flag_op_t op,
                      input logic [7:0] f, input logic [7:0] m, input logic [2:0] idx,
                      input logic [7:0] eq, input bit ee, input bit ef, input bit er,
                      input string name);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    bus8.op  = sel ? OpNop : op;
    bus5.op  = sel ? op : OpNop;
    bus8.f   = f;
    bus8.m   = m;
    bus8.idx = idx;
    bus5.f   = f[4:0];
    bus5.m   = m[4:0];
    bus5.idx = idx;
    e.sel    = sel;
    e.q      = eq;
    e.empty  = ee;
    e.full   = ef;
    e.err    = er;
    e.name   = name;
    sb.push_back(e);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus8.op  = OpNop;
    bus8.f   = '0;
    bus8.m   = '0;
    bus8.idx = '0;
    bus5.op  = OpNop;
    bus5.f   = '0;
    bus5.m   = '0;
    bus5.idx = '0;

    step(0, 1, OpNop,    8'h00, 8'h00, 3'd0, 8'h00, 1, 0, 0, "reset");
    step(0, 0, OpSet,    8'h00, 8'h00, 3'd0, 8'h01, 1, 0, 0, "set0");
    step(0, 0, OpSet,    8'h00, 8'h00, 3'd3, 8'h09, 1, 0, 0, "set3");
    step(0, 0, OpClr,    8'h00, 8'h00, 3'd0, 8'h08, 1, 0, 0, "clr0");
    step(0, 0, OpToggle, 8'h00, 8'h00, 3'd3, 8'h00, 1, 0, 0, "tog3");
    step(0, 0, OpLoad,   8'hA5, 8'h00, 3'd0, 8'hA5, 1, 0, 0, "load_a5");
    step(0, 0, OpLoadm,  8'h0F, 8'h3C, 3'd0, 8'h8D, 1, 0, 0, "loadm");

    step(0, 0, OpLoad,   8'h11, 8'h00, 3'd0, 8'h11, 1, 0, 0, "load_11");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h11, 0, 0, 0, "push_11");
    step(0, 0, OpLoad,   8'h22, 8'h00, 3'd0, 8'h22, 0, 0, 0, "load_22");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h22, 0, 0, 0, "push_22");
    step(0, 0, OpLoad,   8'h33, 8'h00, 3'd0, 8'h33, 0, 0, 0, "load_33");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h22, 0, 0, 0, "pop_22");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h11, 1, 0, 0, "pop_11");

    step(0, 0, OpLoad,   8'h01, 8'h00, 3'd0, 8'h01, 1, 0, 0, "load_01");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h01, 0, 0, 0, "push1");
    step(0, 0, OpLoad,   8'h02, 8'h00, 3'd0, 8'h02, 0, 0, 0, "load_02");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h02, 0, 0, 0, "push2");
    step(0, 0, OpLoad,   8'h03, 8'h00, 3'd0, 8'h03, 0, 0, 0, "load_03");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h03, 0, 0, 0, "push3");
    step(0, 0, OpLoad,   8'h04, 8'h00, 3'd0, 8'h04, 0, 0, 0, "load_04");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h04, 0, 1, 0, "push4_full");
    step(0, 0, OpLoad,   8'hEE, 8'h00, 3'd0, 8'hEE, 0, 1, 0, "load_ee");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'hEE, 0, 1, 1, "push5_drop");
    step(0, 0, OpLoad,   8'hFF, 8'h00, 3'd0, 8'hFF, 0, 1, 0, "err_clear");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h04, 0, 0, 0, "pop4");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h03, 0, 0, 0, "pop3");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h02, 0, 0, 0, "pop2");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h01, 1, 0, 0, "pop1");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h01, 1, 0, 1, "pop5_drop");
    step(0, 0, OpNop,    8'h00, 8'h00, 3'd0, 8'h01, 1, 0, 0, "pop_err_clear");

    step(0, 0, OpLoad,   8'h55, 8'h00, 3'd0, 8'h55, 1, 0, 0, "load_55");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h55, 0, 0, 0, "rpush1");
    step(0, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h55, 0, 0, 0, "rpush2");
    step(0, 1, OpPop,    8'h00, 8'h00, 3'd0, 8'h00, 1, 0, 0, "reset_pop");
    step(0, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h00, 1, 0, 1, "pop_after_reset");

    step(1, 0, OpLoad,   8'h0A, 8'h00, 3'd0, 8'h0A, 1, 0, 0, "w5_load_0a");
    step(1, 0, OpSet,    8'h00, 8'h00, 3'd6, 8'h0A, 1, 0, 0, "w5_set6");
    step(1, 0, OpToggle, 8'h00, 8'h00, 3'd7, 8'h0A, 1, 0, 0, "w5_tog7");
    step(1, 0, OpSet,    8'h00, 8'h00, 3'd4, 8'h1A, 1, 0, 0, "w5_set4");
    step(1, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h1A, 0, 1, 0, "w5_push");
    step(1, 0, OpPush,   8'h00, 8'h00, 3'd0, 8'h1A, 0, 1, 1, "w5_push_drop");
    step(1, 0, OpLoad,   8'h03, 8'h00, 3'd0, 8'h03, 0, 1, 0, "w5_load_03");
    step(1, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h1A, 1, 0, 0, "w5_pop");
    step(1, 0, OpPop,    8'h00, 8'h00, 3'd0, 8'h1A, 1, 0, 1, "w5_pop_drop");

    @(negedge clk);
    bus8.op = OpNop;
    bus5.op = OpNop;
    repeat (3) @(posedge clk);
    #2;
    check("drain", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
